// File: rtl/load_seq_unit.sv
// rtl/load_seq_unit.sv - Load sequencer: issues one memory read per accepted load and returns the extended result
module load_seq_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  LScontrol,
    input  logic [31:0] address,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] LS_output,
    output logic        addr_err
);

    localparam logic [2:0] LW  = 3'b001;
    localparam logic [2:0] LH  = 3'b010;
    localparam logic [2:0] LB  = 3'b011;
    localparam logic [2:0] LHU = 3'b110;
    localparam logic [2:0] LBU = 3'b111;

    // WAIT occupies MEM_WAIT-1 cycles; the counter is loaded on leaving READ.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, CAPTURE} state_t;

    state_t      state, state_nx;
    logic [3:0]  wait_cnt, wait_cnt_nx;
    logic [2:0]  code_q;
    logic        code_ok, misaligned, accept, reject;

    function automatic logic [31:0] extract(input logic [2:0] code, input logic [31:0] d);
        case (code)
            LW:      return d;
            LH:      return {{16{d[15]}}, d[15:0]};
            LHU:     return {16'h0000, d[15:0]};
            LB:      return {{24{d[7]}}, d[7:0]};
            LBU:     return {24'h000000, d[7:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    always_comb begin
        code_ok    = (LScontrol == LW) || (LScontrol == LH) || (LScontrol == LB) ||
                     (LScontrol == LHU) || (LScontrol == LBU);
        misaligned = ((LScontrol == LW) && (address[1:0] != 2'b00)) ||
                     (((LScontrol == LH) || (LScontrol == LHU)) && address[0]);
        // Invalid codes are dropped silently, so they never raise addr_err.
        accept     = (state == IDLE) && start && code_ok && !misaligned;
        reject     = (state == IDLE) && start && code_ok && misaligned;
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        mem_rd      = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_nx = READ;
            end
            READ: begin
                mem_rd = 1'b1;
                if (MEM_WAIT <= 1) begin
                    state_nx = CAPTURE;
                end else begin
                    state_nx    = WAIT;
                    wait_cnt_nx = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nx    = CAPTURE;
                    wait_cnt_nx = 4'd0;
                end else begin
                    wait_cnt_nx = wait_cnt - 4'd1;
                end
            end
            CAPTURE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // mem_addr doubles as the latched load address; it only moves on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            code_q    <= 3'b000;
            mem_addr  <= 32'h0000_0000;
            LS_output <= 32'h0000_0000;
            done      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            done     <= (state == CAPTURE);
            addr_err <= reject;
            if (accept) begin
                mem_addr <= address;
                code_q   <= LScontrol;
            end
            if (state == CAPTURE) LS_output <= extract(code_q, mem_data_in);
        end
    end

endmodule
